esfa_cmd_engine: RTL and testbench

ESFA_CMD_ENGINE -- requirements
Module: esfa_cmd_engine

---
 rtl/esfa_cmd_engine.sv | 148 ++++++++++++++
 tb/tb_esfa_cmd_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/esfa_cmd_engine.sv
// ESFA command engine: two-stage pipeline, tagged storage,
// metadata register and occupancy tracking.
module esfa_cmd_engine #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic                in_valid,
  input  logic [6*DATA_W-1:0] data_in,
  output logic                out_valid,
  output logic [6*DATA_W-1:0] data_out
);

  localparam int W     = 6 * DATA_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [DATA_W:0] DEPTH_C =
    (DATA_W + 1)'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_MAX =
    OCC_W'(DEPTH);

  // S1 pipeline register
  logic          s1_valid;
  logic          s1_mode;
  logic [W-1:0]  s1_data;

  // architectural state
  logic [DEPTH-1:0]  ent_vld;
  logic [DATA_W-1:0] ent_val [DEPTH];
  logic [OCC_W-1:0]  occ;
  logic [DATA_W-1:0] meta;

  // decoded S1 command fields
  logic              will_wr;
  logic              clr;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] wval;
  logic [DATA_W-1:0] meta_in;
  logic              is_meta;
  logic [DATA_W-1:0] sel;

  logic              sel_ok;
  logic              idx_ok;
  logic [IDX_W-1:0]  sel_i;
  logic [IDX_W-1:0]  idx_i;
  logic              hit;
  logic [DATA_W-1:0] rd_val;

  logic              exec;
  logic              do_clr;
  logic              do_meta;
  logic              do_wr;
  logic [OCC_W-1:0]  occ_nxt;
  logic [W-1:0]      res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_mode <= mode;
      s1_data <= data_in;
    end
  end

  always_comb begin
    will_wr = s1_data[0];
    clr     = s1_data[1];
    idx     = s1_data[2*DATA_W-1:DATA_W];
    wval    = s1_data[3*DATA_W-1:2*DATA_W];
    meta_in = s1_data[4*DATA_W-1:3*DATA_W];
    is_meta = s1_data[4*DATA_W];
    sel     = s1_data[6*DATA_W-1:5*DATA_W];
  end

  assign sel_ok = {1'b0, sel} < DEPTH_C;
  assign idx_ok = {1'b0, idx} < DEPTH_C;
  assign sel_i  = sel[IDX_W-1:0];
  assign idx_i  = idx[IDX_W-1:0];

  // lookup sees state as it stood before this command
  assign hit    = sel_ok && ent_vld[sel_i];
  assign rd_val = hit ? ent_val[sel_i] : '0;

  assign exec    = s1_valid && s1_mode;
  assign do_clr  = exec && clr;
  assign do_meta = exec && !clr && is_meta;
  assign do_wr   = exec && !clr && !is_meta
                && will_wr && idx_ok;

  always_comb begin
    occ_nxt = occ;
    if (do_clr) begin
      occ_nxt = '0;
    end else if (do_wr && !ent_vld[idx_i]
                 && occ != OCC_MAX) begin
      occ_nxt = occ + OCC_W'(1);
    end
  end

  always_comb begin
    res = '0;
    res[0] = hit;
    res[2*DATA_W-1:DATA_W]   = rd_val;
    res[3*DATA_W-1:2*DATA_W] = DATA_W'(occ_nxt);
    res[4*DATA_W-1:3*DATA_W] = meta;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_vld   <= '0;
      occ       <= '0;
      meta      <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= s1_valid;
      occ       <= occ_nxt;
      if (s1_valid) begin
        data_out <= s1_mode ? res : s1_data;
      end
      if (do_clr) begin
        ent_vld <= '0;
      end else if (do_wr) begin
        ent_vld[idx_i] <= 1'b1;
      end
      if (do_meta) begin
        meta <= meta_in;
      end
    end
  end

  // payload needs no reset; validity lives in ent_vld
  always_ff @(posedge clk) begin
    if (rst_n && do_wr) begin
      ent_val[idx_i] <= wval;
    end
  end

endmodule

// File: tb/tb_esfa_cmd_engine.sv
// Directed + random bench for esfa_cmd_engine with an
// issue-time reference model feeding a result queue.
module tb_esfa_cmd_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic [47:0] data_in;
  logic        out_valid;
  logic [47:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [47:0] q[$];
  logic        s1v = 1'b0;
  logic        s2v = 1'b0;
  logic [47:0] exp_out = '0;

  logic [15:0] m_vld;
  logic [7:0]  m_val [16];
  logic [7:0]  m_occ;
  logic [7:0]  m_meta;

  esfa_cmd_engine #(.DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk(
    input logic [7:0] sel,
    input logic       im,
    input logic [7:0] md,
    input logic [7:0] val,
    input logic [7:0] idx,
    input logic       clr,
    input logic       ww
  );
    return {sel, 7'b0, im, md, val, idx, 6'b0, clr, ww};
  endfunction

  task automatic model_reset();
    m_vld  = '0;
    m_occ  = '0;
    m_meta = '0;
  endtask

  function automatic logic [47:0] model(
    input logic md, input logic [47:0] d
  );
    logic [7:0] sel, idx, rv, om;
    logic       h;
    if (!md) return d;
    sel = d[47:40];
    idx = d[15:8];
    h   = (sel < 8'd16) && m_vld[sel[3:0]];
    rv  = h ? m_val[sel[3:0]] : 8'h00;
    om  = m_meta;
    if (d[1]) begin
      m_vld = '0;
      m_occ = '0;
    end else if (d[32]) begin
      m_meta = d[31:24];
    end else if (d[0] && idx < 8'd16) begin
      if (!m_vld[idx[3:0]]) m_occ = m_occ + 8'd1;
      m_vld[idx[3:0]] = 1'b1;
      m_val[idx[3:0]] = d[23:16];
    end
    return {16'h0, om, m_occ, rv, 7'b0, h};
  endfunction

  task automatic cycle(
    input string       tag,
    input logic        v,
    input logic        md,
    input logic [47:0] d,
    input logic        rs = 1'b1
  );
    rst_n    = rs;
    in_valid = v;
    mode     = md;
    data_in  = d;
    if (rs && v) q.push_back(model(md, d));
    @(posedge clk);
    #1;
    if (!rs) begin
      model_reset();
      q.delete();
      s2v     = 1'b0;
      s1v     = 1'b0;
      exp_out = '0;
    end else begin
      s2v = s1v;
      s1v = v;
      if (s2v) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL %s: queue empty, no expected value", tag);
        end else begin
          exp_out = q.pop_front();
        end
      end
    end
    checks++;
    assert (out_valid === s2v) else begin
      errors++;
      $error("FAIL %s: out_valid=%b expected %b",
             tag, out_valid, s2v);
    end
    checks++;
    assert (data_out === exp_out) else begin
      errors++;
      $error("FAIL %s: data_out=%h expected %h",
             tag, data_out, exp_out);
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, '0);
  endtask

  task automatic cmd(input string tag, input logic [47:0] d);
    cycle(tag, 1'b1, 1'b1, d);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 1'b0;
    data_in  = '0;
    model_reset();

    cycle("reset0", 1'b1, 1'b1, mk(8'd0, 0, 0, 8'h12, 8'd0, 0, 1), 1'b0);
    cycle("reset1", 1'b0, 1'b0, '0, 1'b0);
    idle("post_reset", 2);

    cycle("pass", 1'b1, 1'b0, 48'h0123_4567_89AB);
    idle("pass_drain", 3);

    cmd("wr3", mk(8'd0, 0, 0, 8'h5A, 8'd3, 0, 1));
    cmd("rd3", mk(8'd3, 0, 0, 8'h00, 8'd0, 0, 0));
    cmd("wr4_rd4", mk(8'd4, 0, 0, 8'h77, 8'd4, 0, 1));
    cmd("rd4", mk(8'd4, 0, 0, 8'h00, 8'd0, 0, 0));

    cmd("ow3a", mk(8'd3, 0, 0, 8'h11, 8'd3, 0, 1));
    cmd("ow3b", mk(8'd3, 0, 0, 8'h22, 8'd3, 0, 1));
    cmd("wr7", mk(8'd0, 0, 0, 8'h33, 8'd7, 0, 1));
    cmd("rd3_again", mk(8'd3, 0, 0, 8'h00, 8'd0, 0, 0));

    cmd("wr16_selff", mk(8'hFF, 0, 0, 8'hEE, 8'd16, 0, 1));
    cmd("rd16", mk(8'd16, 0, 0, 8'h00, 8'd0, 0, 0));

    cmd("meta_c3", mk(8'd9, 1, 8'hC3, 8'h99, 8'd9, 0, 1));
    cmd("meta_rd9", mk(8'd9, 0, 0, 8'h00, 8'd0, 0, 0));

    for (int i = 0; i < 16; i++)
      cmd("fill", mk(8'(i), 0, 0, 8'(8'hA0 + i), 8'(i), 0, 1));
    cmd("full_rd", mk(8'd15, 0, 0, 8'h00, 8'd0, 0, 0));

    cmd("clr_all", mk(8'd5, 1, 8'h55, 8'h66, 8'd1, 1, 1));
    for (int i = 0; i < 16; i++)
      cmd("clr_rd", mk(8'(i), 0, 0, 8'h00, 8'd0, 0, 0));
    idle("clr_drain", 2);

    cmd("rst_w10", mk(8'd0, 0, 0, 8'h10, 8'd10, 0, 1));
    cmd("rst_w11", mk(8'd0, 0, 0, 8'h11, 8'd11, 0, 1));
    cycle("rst_w12", 1'b1, 1'b1,
          mk(8'd0, 0, 0, 8'h12, 8'd12, 0, 1), 1'b0);
    idle("rst_after", 2);
    cmd("rst_rd10", mk(8'd10, 0, 0, 8'h00, 8'd0, 0, 0));
    cmd("rst_rd11", mk(8'd11, 0, 0, 8'h00, 8'd0, 0, 0));
    cmd("rst_rd12", mk(8'd12, 0, 0, 8'h00, 8'd0, 0, 0));
    idle("rst_drain", 2);

    for (int i = 0; i < 60; i++) begin
      logic [47:0] d;
      logic        v, md;
      d  = mk(8'($urandom_range(0, 20)),
              ($urandom_range(0, 7) == 0),
              8'($urandom),
              8'($urandom),
              8'($urandom_range(0, 20)),
              ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 3) != 0));
      v  = ($urandom_range(0, 4) != 0);
      md = ($urandom_range(0, 5) != 0);
      cycle("rand", v, md, v ? d : 48'h0);
    end
    idle("final_drain", 3);

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL leftover: queue size=%0d expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
